pwm_level_ramp: RTL and testbench

- Slew-limited level generator that drives the 8-bit `PWM_source` input of the PWM DAC stage.
- Accepts a host-programmed target level over a valid/ready handshake and gates it with a transmit enable.
- Steps its output toward the effective goal at a programmable rate, so the DAC-derived analogue control voltage never jumps.
- Sits between the register/protocol layer and the PWM DAC, in the 122.88 MHz domain.

---
 rtl/pwm_ramp_pkg.sv | 41 ++++
 rtl/pwm_ramp_tick.sv | 30 +++
 rtl/pwm_level_ramp.sv | 134 +++++++++++++
 tb/tb_pwm_level_ramp.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_pkg.sv
// Shared types and saturating step helpers for the PWM level ramp.
// Steps are computed one bit wider than the level so they never wrap.
package pwm_ramp_pkg;

  localparam int LEVEL_W = 8;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_t;

  function automatic level_t step_up(input level_t level, input level_t goal, input level_t step);
    logic [LEVEL_W:0] sum;
    level_t           result;
    sum = {1'b0, level} + {1'b0, step};
    if (sum > {1'b0, goal}) begin
      result = goal;
    end else begin
      result = sum[LEVEL_W-1:0];
    end
    return result;
  endfunction

  // A set borrow bit means the subtraction went below zero.
  function automatic level_t step_down(input level_t level, input level_t goal, input level_t step);
    logic [LEVEL_W:0] diff;
    level_t           result;
    diff = {1'b0, level} - {1'b0, step};
    if (diff[LEVEL_W] || (diff[LEVEL_W-1:0] < goal)) begin
      result = goal;
    end else begin
      result = diff[LEVEL_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_ramp_tick.sv
// Ramp-rate prescaler: emits a single-cycle tick every i_rate_div+1 cycles.
// i_clear restarts the count so the first tick lands i_rate_div+1 cycles later.
module pwm_ramp_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic [DIV_WIDTH-1:0] i_rate_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_count;
  logic                 w_hit;

  assign w_hit  = (r_count == i_rate_div);
  assign o_tick = w_hit && !i_clear;

  // A count already above a freshly lowered i_rate_div wraps through the full range.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (w_hit) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_level_ramp.sv
// Slew-limited level generator feeding the PWM DAC PWM_source input.
// Walks level_out toward (enable ? accepted target : 0) one STEP per prescaler tick.
module pwm_level_ramp
  import pwm_ramp_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int STEP      = 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [LEVEL_W-1:0]   target_level,
  input  logic                 target_valid,
  output logic                 target_ready,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] rate_div,
  output logic [LEVEL_W-1:0]   level_out,
  output logic                 settled
);

  localparam level_t STEP_L = level_t'(STEP);

  ramp_state_t r_state;
  level_t      r_target;
  level_t      r_level;
  logic        r_ready;
  logic        r_settled;

  level_t      w_goal;
  level_t      w_up_level;
  level_t      w_dn_level;
  logic        w_go_up;
  logic        w_go_dn;
  logic        w_accept;
  logic        w_ramping;
  logic        w_enter_ramp;
  logic        w_clear;
  logic        w_tick;

  assign w_goal     = enable ? r_target : '0;
  assign w_go_up    = (w_goal > r_level);
  assign w_go_dn    = (w_goal < r_level);
  assign w_accept   = target_valid && r_ready;
  assign w_up_level = step_up(r_level, w_goal, STEP_L);
  assign w_dn_level = step_down(r_level, w_goal, STEP_L);

  // Entry covers both a start from IDLE/HOLD and a direction reversal.
  assign w_ramping    = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);
  assign w_enter_ramp = (w_go_up && (r_state != RAMP_UP)) ||
                        (w_go_dn && (r_state != RAMP_DOWN));
  assign w_clear      = w_enter_ramp || !w_ramping;

  pwm_ramp_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .i_clk      (aclk),
    .i_rst      (areset),
    .i_clear    (w_clear),
    .i_rate_div (rate_div),
    .o_tick     (w_tick)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= IDLE;
      r_target  <= '0;
      r_level   <= '0;
      r_ready   <= 1'b1;
      r_settled <= 1'b1;
    end else begin
      if (w_accept) begin
        r_target <= target_level;
      end

      case (r_state)
        IDLE, HOLD: begin
          if (w_go_up) begin
            r_state   <= RAMP_UP;
            r_ready   <= 1'b0;
            r_settled <= 1'b0;
          end else if (w_go_dn) begin
            r_state   <= RAMP_DOWN;
            r_ready   <= 1'b0;
            r_settled <= 1'b0;
          end
        end

        RAMP_UP: begin
          if (w_go_dn) begin
            r_state <= RAMP_DOWN;
          end else if (!w_go_up) begin
            r_state   <= (w_goal == '0) ? IDLE : HOLD;
            r_ready   <= 1'b1;
            r_settled <= 1'b1;
          end else if (w_tick) begin
            r_level <= w_up_level;
            if (w_up_level == w_goal) begin
              r_state   <= HOLD;
              r_ready   <= 1'b1;
              r_settled <= 1'b1;
            end
          end
        end

        RAMP_DOWN: begin
          if (w_go_up) begin
            r_state <= RAMP_UP;
          end else if (!w_go_dn) begin
            r_state   <= (w_goal == '0) ? IDLE : HOLD;
            r_ready   <= 1'b1;
            r_settled <= 1'b1;
          end else if (w_tick) begin
            r_level <= w_dn_level;
            if (w_dn_level == w_goal) begin
              r_state   <= (w_goal == '0) ? IDLE : HOLD;
              r_ready   <= 1'b1;
              r_settled <= 1'b1;
            end
          end
        end

        default: begin
          r_state   <= IDLE;
          r_ready   <= 1'b1;
          r_settled <= 1'b1;
        end
      endcase
    end
  end

  assign level_out    = r_level;
  assign target_ready = r_ready;
  assign settled      = r_settled;

endmodule

// File: tb/tb_pwm_level_ramp.sv
// Directed bench for pwm_level_ramp: three instances (STEP 1, 64, 7) share stimulus,
// each scenario checks the instance whose step size it exercises.
module tb_pwm_level_ramp;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  target_level;
  logic        target_valid;
  logic        enable;
  logic [15:0] rate_div;

  logic        ready_a, settled_a;
  logic [7:0]  level_a;
  logic        ready_b, settled_b;
  logic [7:0]  level_b;
  logic        ready_c, settled_c;
  logic [7:0]  level_c;

  int tests_run    = 0;
  int tests_failed = 0;

  always #4 aclk = ~aclk;

  pwm_level_ramp #(.DIV_WIDTH(16), .STEP(1)) dut_a (
    .aclk(aclk), .areset(areset), .target_level(target_level), .target_valid(target_valid),
    .target_ready(ready_a), .enable(enable), .rate_div(rate_div), .level_out(level_a),
    .settled(settled_a));

  pwm_level_ramp #(.DIV_WIDTH(16), .STEP(64)) dut_b (
    .aclk(aclk), .areset(areset), .target_level(target_level), .target_valid(target_valid),
    .target_ready(ready_b), .enable(enable), .rate_div(rate_div), .level_out(level_b),
    .settled(settled_b));

  pwm_level_ramp #(.DIV_WIDTH(16), .STEP(7)) dut_c (
    .aclk(aclk), .areset(areset), .target_level(target_level), .target_valid(target_valid),
    .target_ready(ready_c), .enable(enable), .rate_div(rate_div), .level_out(level_c),
    .settled(settled_c));

  task automatic wait_clk();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset       = 1'b1;
    target_valid = 1'b0;
    target_level = 8'd0;
    enable       = 1'b0;
    rate_div     = 16'd0;
    repeat (2) wait_clk();
    areset = 1'b0;
  endtask

  // Offer a target for one edge, then move to the edge where the state changes.
  task automatic start_ramp(input logic [7:0] lvl, input logic [15:0] rd);
    target_level = lvl;
    target_valid = 1'b1;
    enable       = 1'b1;
    rate_div     = rd;
    wait_clk();
    target_valid = 1'b0;
    wait_clk();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (level_a !== 8'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level_a); end
    tests_run++;
    if (settled_a !== 1'b1) begin tests_failed++; $display("FAIL reset_settled: got %b expected 1", settled_a); end
    tests_run++;
    if (ready_a !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
    $display("[TB] reset: level=%0d settled=%b ready=%b", level_a, settled_a, ready_a);
  endtask

  task automatic test_ramp_up();
    do_reset();
    target_level = 8'd10;
    target_valid = 1'b1;
    enable       = 1'b1;
    rate_div     = 16'd3;
    wait_clk();
    target_valid = 1'b0;
    tests_run++;
    if (ready_a !== 1'b1) begin tests_failed++; $display("FAIL up_ready_after_accept: got %b expected 1", ready_a); end
    wait_clk();
    tests_run++;
    if (ready_a !== 1'b0 || settled_a !== 1'b0) begin
      tests_failed++; $display("FAIL up_ready_fall: got ready=%b settled=%b expected 0 0", ready_a, settled_a);
    end
    for (int k = 1; k <= 10; k++) begin
      repeat (3) wait_clk();
      tests_run++;
      if (level_a !== 8'(k - 1)) begin tests_failed++; $display("FAIL up_pre_step%0d: got %0d expected %0d", k, level_a, k - 1); end
      wait_clk();
      tests_run++;
      if (level_a !== 8'(k)) begin tests_failed++; $display("FAIL up_step%0d: got %0d expected %0d", k, level_a, k); end
      tests_run++;
      if (settled_a !== (k == 10) || ready_a !== (k == 10)) begin
        tests_failed++; $display("FAIL up_settled%0d: got settled=%b ready=%b expected %b", k, settled_a, ready_a, (k == 10));
      end
    end
    repeat (6) wait_clk();
    tests_run++;
    if (level_a !== 8'd10) begin tests_failed++; $display("FAIL up_hold: got %0d expected 10", level_a); end
    $display("[TB] ramp_up: final level=%0d settled=%b", level_a, settled_a);
  endtask

  task automatic test_fast_down();
    logic [7:0] exp_dn [4] = '{8'd136, 8'd72, 8'd8, 8'd0};
    int n;
    do_reset();
    start_ramp(8'd200, 16'd0);
    n = 0;
    while (settled_b !== 1'b1 && n < 20) begin wait_clk(); n++; end
    tests_run++;
    if (level_b !== 8'd200 || settled_b !== 1'b1) begin
      tests_failed++; $display("FAIL fast_hold: got level=%0d settled=%b expected 200 1", level_b, settled_b);
    end
    enable = 1'b0;
    wait_clk();
    tests_run++;
    if (level_b !== 8'd200 || settled_b !== 1'b0) begin
      tests_failed++; $display("FAIL fast_entry: got level=%0d settled=%b expected 200 0", level_b, settled_b);
    end
    for (int i = 0; i < 4; i++) begin
      wait_clk();
      tests_run++;
      if (level_b !== exp_dn[i]) begin tests_failed++; $display("FAIL fast_down%0d: got %0d expected %0d", i, level_b, exp_dn[i]); end
    end
    tests_run++;
    if (settled_b !== 1'b1 || ready_b !== 1'b1) begin
      tests_failed++; $display("FAIL fast_idle: got settled=%b ready=%b expected 1 1", settled_b, ready_b);
    end
    $display("[TB] fast_down: final level=%0d settled=%b", level_b, settled_b);
  endtask

  task automatic test_reversal();
    int n;
    logic [7:0] max_seen;
    do_reset();
    start_ramp(8'd255, 16'd1);
    n = 0;
    while (level_a !== 8'd50 && n < 300) begin wait_clk(); n++; end
    tests_run++;
    if (level_a !== 8'd50) begin tests_failed++; $display("FAIL rev_reach50: got %0d expected 50", level_a); end
    enable = 1'b0;
    wait_clk();
    tests_run++;
    if (level_a !== 8'd50 || ready_a !== 1'b0) begin
      tests_failed++; $display("FAIL rev_entry: got level=%0d ready=%b expected 50 0", level_a, ready_a);
    end
    wait_clk();
    tests_run++;
    if (level_a !== 8'd50) begin tests_failed++; $display("FAIL rev_prescale_restart: got %0d expected 50", level_a); end
    wait_clk();
    tests_run++;
    if (level_a !== 8'd49) begin tests_failed++; $display("FAIL rev_first_step: got %0d expected 49", level_a); end
    max_seen = level_a;
    n = 0;
    while (settled_a !== 1'b1 && n < 300) begin
      wait_clk();
      n++;
      if (level_a > max_seen) max_seen = level_a;
    end
    tests_run++;
    if (max_seen > 8'd49) begin tests_failed++; $display("FAIL rev_overshoot: got max %0d expected at most 49", max_seen); end
    tests_run++;
    if (level_a !== 8'd0 || settled_a !== 1'b1) begin
      tests_failed++; $display("FAIL rev_final: got level=%0d settled=%b expected 0 1", level_a, settled_a);
    end
    $display("[TB] reversal: max after reversal=%0d final=%0d", max_seen, level_a);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] max_seen;
    do_reset();
    start_ramp(8'd20, 16'd0);
    target_level = 8'd30;
    target_valid = 1'b1;
    tests_run++;
    if (ready_a !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy: got ready=%b expected 0", ready_a); end
    max_seen = level_a;
    n = 0;
    while (settled_a !== 1'b1 && n < 100) begin
      wait_clk();
      n++;
      if (level_a > max_seen) max_seen = level_a;
    end
    tests_run++;
    if (level_a !== 8'd20 || max_seen !== 8'd20) begin
      tests_failed++; $display("FAIL b2b_first_goal: got level=%0d max=%0d expected 20 20", level_a, max_seen);
    end
    wait_clk();
    target_valid = 1'b0;
    tests_run++;
    if (level_a !== 8'd20 || ready_a !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_accept: got level=%0d ready=%b expected 20 1", level_a, ready_a);
    end
    wait_clk();
    tests_run++;
    if (ready_a !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_fall: got %b expected 0", ready_a); end
    wait_clk();
    tests_run++;
    if (level_a !== 8'd21) begin tests_failed++; $display("FAIL b2b_resume: got %0d expected 21", level_a); end
    n = 0;
    while (settled_a !== 1'b1 && n < 100) begin wait_clk(); n++; end
    tests_run++;
    if (level_a !== 8'd30) begin tests_failed++; $display("FAIL b2b_second_goal: got %0d expected 30", level_a); end
    $display("[TB] back_to_back: final level=%0d", level_a);
  endtask

  task automatic test_saturate();
    int n;
    logic [7:0] last, p1, p2;
    logic       wrapped;
    do_reset();
    start_ramp(8'd255, 16'd0);
    last = 8'd0; p1 = 8'd0; p2 = 8'd0; wrapped = 1'b0;
    n = 0;
    while (settled_c !== 1'b1 && n < 100) begin
      wait_clk();
      n++;
      if (level_c != last) begin
        if (level_c < last) wrapped = 1'b1;
        p2 = p1; p1 = last; last = level_c;
      end
    end
    tests_run++;
    if (p2 !== 8'd245 || p1 !== 8'd252 || last !== 8'd255) begin
      tests_failed++; $display("FAIL sat_tail: got %0d,%0d,%0d expected 245,252,255", p2, p1, last);
    end
    tests_run++;
    if (wrapped !== 1'b0) begin tests_failed++; $display("FAIL sat_wrap: got wrap=%b expected 0", wrapped); end
    target_level = 8'd0;
    target_valid = 1'b1;
    wait_clk();
    target_valid = 1'b0;
    wait_clk();
    wait_clk();
    tests_run++;
    if (level_c !== 8'd248) begin tests_failed++; $display("FAIL sat_down_first: got %0d expected 248", level_c); end
    n = 0;
    while (settled_c !== 1'b1 && n < 100) begin wait_clk(); n++; end
    tests_run++;
    if (level_c !== 8'd0 || ready_c !== 1'b1) begin
      tests_failed++; $display("FAIL sat_down_idle: got level=%0d ready=%b expected 0 1", level_c, ready_c);
    end
    $display("[TB] saturate: tail=%0d,%0d,%0d final=%0d", p2, p1, last, level_c);
  endtask

  task automatic test_reset_midramp();
    int n;
    do_reset();
    start_ramp(8'd200, 16'd0);
    n = 0;
    while (level_a !== 8'd128 && n < 300) begin wait_clk(); n++; end
    tests_run++;
    if (level_a !== 8'd128) begin tests_failed++; $display("FAIL rst_reach128: got %0d expected 128", level_a); end
    areset = 1'b1;
    wait_clk();
    tests_run++;
    if (level_a !== 8'd0 || settled_a !== 1'b1 || ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid: got level=%0d settled=%b ready=%b expected 0 1 1", level_a, settled_a, ready_a);
    end
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_clk();
      tests_run++;
      if (level_a !== 8'd0 || settled_a !== 1'b1) begin
        tests_failed++; $display("FAIL rst_target_cleared%0d: got level=%0d settled=%b expected 0 1", i, level_a, settled_a);
      end
    end
    $display("[TB] reset_midramp: level=%0d settled=%b", level_a, settled_a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_fast_down();
    test_reversal();
    test_back_to_back();
    test_saturate();
    test_reset_midramp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
